// File: rtl/incr_pkg.sv
// Shared constants, types and helpers for the incrementing arbiter slice.
package incr_pkg;

    localparam logic [1:0] ID_SMALL = 2'd0;
    localparam logic [1:0] ID_QUAD  = 2'd1;
    localparam logic [1:0] ID_WIDE  = 2'd2;

    localparam int SMALL_W = 2;
    localparam int QUAD_W  = 40;
    localparam int WIDE_W  = 70;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Adds an offset to a requester index, wrapping 2 -> 0.
    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input logic [1:0] offs);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/incr_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the result consumer.
interface incr_arbiter_if;
    import incr_pkg::*;

    logic                en;
    logic [2:0]          req_valid;
    logic [2:0]          req_ready;
    logic [SMALL_W-1:0]  small_data;
    logic [QUAD_W-1:0]   quad_data;
    logic [WIDE_W-1:0]   wide_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [WIDE_W-1:0]   rsp_data;

    modport master (
        output en, req_valid, small_data, quad_data, wide_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  en, req_valid, small_data, quad_data, wide_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: one-hot grant, priority rotates past the last accepted winner.
module rr_arb3
    import incr_pkg::*;
(
    input  logic       clk,
    input  logic       reset_l,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [2:0] grant
);

    logic [1:0] ptr_q;

    // Scan from the priority pointer and grant the first asserted request.
    always_comb begin
        grant = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (grant == 3'b000 && req[wrap_idx(ptr_q, 2'(k))]) begin
                grant[wrap_idx(ptr_q, 2'(k))] = 1'b1;
            end
        end
    end

    // Move priority to the index after the winner, only when the grant is taken.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ptr_q <= 2'd0;
        end else if (advance) begin
            case (grant)
                3'b001:  ptr_q <= 2'd1;
                3'b010:  ptr_q <= 2'd2;
                3'b100:  ptr_q <= 2'd0;
                default: ptr_q <= ptr_q;
            endcase
        end
    end

endmodule

// File: rtl/incr_arbiter.sv
// Arbitrates three requesters onto one shared 70-bit incrementer with a single result register.
module incr_arbiter
    import incr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    incr_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] txn_count
);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        grant;
    logic              consume;
    logic              can_accept;
    logic              accept;
    logic [1:0]        sel_id;
    logic [WIDE_W-1:0] operand;
    logic [WIDE_W-1:0] inc_full;
    logic [WIDE_W-1:0] inc_result;
    logic [1:0]        rsp_id_q;
    logic [WIDE_W-1:0] rsp_data_q;

    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    assign consume    = bus.rsp_valid & bus.rsp_ready;
    assign can_accept = reset_l & bus.en & ((state_q == ST_EMPTY) | consume);
    assign bus.req_ready = can_accept ? grant : 3'b000;
    assign accept     = |bus.req_ready;

    rr_arb3 u_arb (
        .clk     (clk),
        .reset_l (reset_l),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Select the winning operand, increment it once, and wrap at the winner's own width.
    always_comb begin
        sel_id  = ID_SMALL;
        operand = '0;
        case (grant)
            3'b010: begin
                sel_id  = ID_QUAD;
                operand = {{(WIDE_W-QUAD_W){1'b0}}, bus.quad_data};
            end
            3'b100: begin
                sel_id  = ID_WIDE;
                operand = bus.wide_data;
            end
            default: begin
                sel_id  = ID_SMALL;
                operand = {{(WIDE_W-SMALL_W){1'b0}}, bus.small_data};
            end
        endcase
        inc_full = operand + {{(WIDE_W-1){1'b0}}, 1'b1};
        case (sel_id)
            ID_SMALL: inc_result = {{(WIDE_W-SMALL_W){1'b0}}, inc_full[SMALL_W-1:0]};
            ID_QUAD:  inc_result = {{(WIDE_W-QUAD_W){1'b0}}, inc_full[QUAD_W-1:0]};
            default:  inc_result = inc_full;
        endcase
    end

    // Result register occupancy: fills on accept, drains on consume unless refilled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (consume && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the incremented result on accept; otherwise hold it steady.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rsp_id_q   <= 2'd0;
            rsp_data_q <= '0;
        end else if (accept) begin
            rsp_id_q   <= sel_id;
            rsp_data_q <= inc_result;
        end
    end

    // Count accepted requests, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            txn_count <= '0;
        end else if (accept) begin
            txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_incr_arbiter.sv
// Randomized and directed bench for incr_arbiter against a transaction-level reference model.
module tb_incr_arbiter;

    logic        clk;
    logic        reset_l;
    logic [15:0] txn_count;

    incr_arbiter_if bus ();

    incr_arbiter #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .bus       (bus),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: occupancy, expected held result, last winner, count.
    bit          m_full;
    logic [1:0]  m_id;
    logic [69:0] m_data;
    int          m_last;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_id   = 2'd0;
        m_data = '0;
        m_last = 2;
        m_cnt  = 0;
    endtask

    task automatic apply_stimulus(input bit e, input logic [2:0] v, input logic [1:0] sd,
                                  input logic [39:0] qd, input logic [69:0] wd, input bit rr);
        bus.en         = e;
        bus.req_valid  = v;
        bus.small_data = sd;
        bus.quad_data  = qd;
        bus.wide_data  = wd;
        bus.rsp_ready  = rr;
    endtask

    task automatic check_output();
        chk("rsp_valid", 70'(bus.rsp_valid), 70'(m_full));
        if (m_full) begin
            chk("rsp_id", 70'(bus.rsp_id), 70'(m_id));
            chk("rsp_data", bus.rsp_data, m_data);
        end
        chk("txn_count", 70'(txn_count), 70'(m_cnt[15:0]));
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic cycle();
        logic [2:0]  exp_ready;
        logic [70:0] ext;
        logic [70:0] mask;
        int          g;
        #1;
        exp_ready = 3'b000;
        g = -1;
        if (bus.en && (!m_full || bus.rsp_ready)) begin
            for (int k = 1; k <= 3; k++) begin
                if (g < 0 && bus.req_valid[(m_last + k) % 3]) g = (m_last + k) % 3;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 70'(bus.req_ready), 70'(exp_ready));
        @(posedge clk);
        if (m_full && bus.rsp_ready) m_full = 1'b0;
        if (g >= 0) begin
            case (g)
                0:       begin ext = 71'(bus.small_data); mask = (71'd1 << 2) - 71'd1;  end
                1:       begin ext = 71'(bus.quad_data);  mask = (71'd1 << 40) - 71'd1; end
                default: begin ext = 71'(bus.wide_data);  mask = (71'd1 << 70) - 71'd1; end
            endcase
            m_full = 1'b1;
            m_id   = 2'(g);
            m_data = 70'((ext + 71'd1) & mask);
            m_last = g;
            m_cnt  = (m_cnt + 1) % 65536;
        end
        #1;
        check_output();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        reset_l = 1'b0;
        apply_stimulus(1'b1, 3'b111, 2'd0, 40'd0, 70'd0, 1'b1);
        #1;
        chk("reset_req_ready", 70'(bus.req_ready), 70'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 70'(bus.rsp_valid), 70'd0);
        chk("reset_rsp_id", 70'(bus.rsp_id), 70'd0);
        chk("reset_rsp_data", bus.rsp_data, 70'd0);
        chk("reset_txn", 70'(txn_count), 70'd0);
        reset_l = 1'b1;

        $display("[TB] round-robin with all requesters valid");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 3'b111, 2'($urandom), {$urandom, $urandom} , {$urandom, $urandom, $urandom}, 1'b1);
            #1;
            chk("rr_order", 70'(bus.req_ready), 70'(3'b001 << (i % 3)));
            cycle();
        end
        chk("txn_after_six", 70'(txn_count), 70'd6);

        $display("[TB] small wrap 3 -> 0");
        apply_stimulus(1'b1, 3'b001, 2'd3, 40'd0, 70'd0, 1'b1);
        cycle();
        chk("small_wrap_id", 70'(bus.rsp_id), 70'd0);
        chk("small_wrap_data", bus.rsp_data, 70'd0);

        $display("[TB] wide and quad wrap");
        apply_stimulus(1'b1, 3'b100, 2'd0, 40'd0, {70{1'b1}}, 1'b1);
        cycle();
        chk("wide_wrap_id", 70'(bus.rsp_id), 70'd2);
        chk("wide_wrap_data", bus.rsp_data, 70'd0);
        apply_stimulus(1'b1, 3'b010, 2'd0, 40'hFF_FFFF_FFFF, 70'd0, 1'b1);
        cycle();
        chk("quad_wrap_data", bus.rsp_data, 70'd0);

        $display("[TB] stall with result held");
        apply_stimulus(1'b1, 3'b111, 2'd1, 40'h12_3456_789A, 70'h3_0000_0000_0000_0005, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
        end
        apply_stimulus(1'b1, 3'b111, 2'd2, 40'h00_0000_0010, 70'h1, 1'b1);
        cycle();
        cycle();

        $display("[TB] enable low blocks grants, result drains");
        apply_stimulus(1'b1, 3'b111, 2'd0, 40'd7, 70'd9, 1'b0);
        cycle();
        apply_stimulus(1'b0, 3'b111, 2'd0, 40'd7, 70'd9, 1'b0);
        cycle();
        apply_stimulus(1'b0, 3'b111, 2'd0, 40'd7, 70'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
        end

        $display("[TB] asynchronous reset while full");
        apply_stimulus(1'b1, 3'b111, 2'd1, 40'd5, 70'd6, 1'b0);
        cycle();
        #2;
        reset_l = 1'b0;
        #1;
        chk("areset_rsp_valid", 70'(bus.rsp_valid), 70'd0);
        chk("areset_txn", 70'(txn_count), 70'd0);
        chk("areset_req_ready", 70'(bus.req_ready), 70'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        apply_stimulus(1'b1, 3'b111, 2'd2, 40'd3, 70'd4, 1'b1);
        #1;
        chk("first_grant_after_reset", 70'(bus.req_ready), 70'd1);
        cycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 7) != 0, 3'($urandom), 2'($urandom),
                           {$urandom, $urandom}, {$urandom, $urandom, $urandom},
                           $urandom_range(0, 9) < 7);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/incr_arbiter.md
INCR_ARBITER -- requirements
Module: incr_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the accepted-transaction counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_l  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  grant enable; low blocks new grants, pending result still drains.
REQ-005 SHALL have port req_valid  input  3  per-requester request, bit0=small, bit1=quad, bit2=wide.
REQ-006 SHALL have port req_ready  output  3  per-requester accept, one-hot or zero.
REQ-007 SHALL have ports small_data  input  2, quad_data  input  40, wide_data  input  70  operands per requester.
REQ-008 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  2  requester index of the held result (0 small, 1 quad, 2 wide).
REQ-011 SHALL have port rsp_data  output  70  incremented operand, zero-extended.
REQ-012 SHALL have port txn_count  output  CNT_W  count of accepted requests.

Function
REQ-013 SHALL share one 70-bit incrementer among the three requesters.
REQ-014 SHALL accept a request (valid & ready) only when en=1 and the result register is empty or is being consumed in the same cycle (rsp_valid & rsp_ready).
REQ-015 SHALL select among asserted req_valid by round-robin: the search starts at the index after the last granted, wrapping 2->0. After reset the search starts at index 0.
REQ-016 SHALL assert req_ready combinationally for exactly the selected requester. It SHALL NOT depend on that requester's own data.
REQ-017 SHALL present the result one cycle after acceptance: rsp_valid=1, with rsp_id set and rsp_data equal to the operand+1.
REQ-018 SHALL wrap each increment at its own width: small mod 4 (3->0), quad mod 2^40, wide mod 2^70. Upper bits of rsp_data SHALL be zero for small and quad.
REQ-019 SHALL hold rsp_valid, rsp_id and rsp_data stable while rsp_valid=1 and rsp_ready=0.
REQ-020 SHALL, on a simultaneous consume and accept, load the new result with no bubble, sustaining one result per cycle.
REQ-021 SHALL implement a two-state FSM:
- EMPTY goes to FULL on accept.
- FULL goes to EMPTY on consume without accept.
- FULL stays FULL on consume with accept or on stall.
REQ-022 SHALL increment txn_count by 1 per accept, wrapping at 2^CNT_W to 0.
REQ-023 SHALL, when en falls while FULL, keep the result until consumed and then grant nothing.
REQ-024 SHALL advance the round-robin pointer only on an accept.

Reset
REQ-025 SHALL, while reset_l=0, asynchronously force:
- FSM to EMPTY
- rsp_valid=0, rsp_id=0, rsp_data=0
- txn_count=0
- round-robin pointer so index 0 has priority
- req_ready=0
REQ-026 SHALL, on reset mid-transfer, discard the held result. No accept SHALL occur in the reset cycle.

Structure
REQ-027 SHALL take from shared package incr_pkg:
- requester index constants ID_SMALL=0, ID_QUAD=1, ID_WIDE=2
- width constants 2/40/70
- the FSM state typedef
REQ-028 SHALL instantiate one sub-module rr_arb3: a three-way round-robin arbiter (request vector, advance strobe in; one-hot grant out).

Verification
REQ-029 SHALL cover: only small valid, small_data=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0.
REQ-030 SHALL cover: all three valid continuously, rsp_ready=1 -> grants 0,1,2,0,1,2 on consecutive cycles, one result per cycle, txn_count=6 after six cycles.
REQ-031 SHALL cover: wide_data=2^70-1 accepted -> rsp_data=0, rsp_id=2. Also quad_data=40'hFF_FFFF_FFFF -> rsp_data=0.
REQ-032 SHALL cover: rsp_ready=0 for 5 cycles with FULL -> req_ready=0 and rsp_* stable throughout; on the rsp_ready rise the next accept occurs in the same cycle.
REQ-033 SHALL cover: en=0 with all valid -> no grant, txn_count unchanged; a pending result still drains.
REQ-034 SHALL cover: reset_l pulsed low asynchronously while FULL -> rsp_valid=0 immediately, txn_count=0; the first grant after reset goes to index 0.
